// File: rtl/cic_pkg.sv
// Shared CIC constants and helpers used by both the interpolator and the decimator.
package cic_pkg;

    // Ceiling log2 for elaboration-time width derivation.
    function automatic int CLOG2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int CIC_IW = 10;
    localparam int CIC_OW = 17;
    localparam int CIC_R  = 8;
    localparam int CIC_N  = 3;
    localparam int CIC_M  = 1;

    // Full-precision internal width for the default configuration.
    localparam int CIC_W  = CIC_IW + CIC_N * CLOG2(CIC_R * CIC_M);

endpackage

// File: rtl/cic_interp_if.sv
// Sample-source / sink bundle of the CIC interpolator.
// The underrun flag exists only when CIC_UNDERRUN_EN is defined.
interface cic_interp_if
    import cic_pkg::*;
#(
    parameter int IW = CIC_IW,
    parameter int OW = CIC_OW
);
    logic signed [IW-1:0] Xin;
    logic                 in_vld;
    logic                 in_rdy;
    logic signed [OW-1:0] Yout;
    logic                 rdy;
`ifdef CIC_UNDERRUN_EN
    logic                 underrun;
`endif

`ifdef CIC_UNDERRUN_EN
    modport master (output Xin, in_vld, input in_rdy, Yout, rdy, underrun);
    modport slave  (input Xin, in_vld, output in_rdy, Yout, rdy, underrun);
`else
    modport master (output Xin, in_vld, input in_rdy, Yout, rdy);
    modport slave  (input Xin, in_vld, output in_rdy, Yout, rdy);
`endif

endinterface

// File: rtl/cic_int_stage.sv
// One wrap-around integrator of the CIC chain; the output may be narrower
// than the accumulator since modular sums only depend on low bits.
module cic_int_stage
    import cic_pkg::*;
#(
    parameter int W     = CIC_W,
    parameter int OUT_W = CIC_W
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic signed [W-1:0]     din_i,
    output logic signed [OUT_W-1:0] acc_o
);
    logic signed [W-1:0] acc_q;
    logic signed [W-1:0] acc_d;

    // Next accumulator value, modulo 2^W.
    always_comb begin
        acc_d = acc_q;
        if (en_i) begin
            acc_d = acc_q + din_i;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = OUT_W'(acc_q);

endmodule

// File: rtl/cic_interp.sv
// N-stage CIC interpolator: low-rate combs, zero-stuff by R, clk-rate integrators.
// Optional sticky underrun flag enabled by defining CIC_UNDERRUN_EN.
module cic_interp
    import cic_pkg::*;
#(
    parameter int IW = CIC_IW,
    parameter int OW = CIC_OW,
    parameter int R  = CIC_R,
    parameter int N  = CIC_N,
    parameter int M  = CIC_M
)(
    input  logic        clk,
    input  logic        rst,
    cic_interp_if.slave bus
);
    localparam int W  = IW + N * CLOG2(R * M);
    localparam int PW = (CLOG2(R) < 1) ? 1 : CLOG2(R);
    localparam logic [PW-1:0] PH_LAST = PW'(R - 1);

    logic [PW-1:0]        phase_q;
    logic [PW-1:0]        phase_d;
    logic                 accept_s;
    logic signed [W-1:0]  c_s   [N+1];
    logic signed [W-1:0]  dly_q [N][M];
    logic signed [W-1:0]  u_s;
    logic signed [W-1:0]  u_reg_q;
    logic signed [W-1:0]  i_s   [N];
    logic signed [OW-1:0] yacc_s;
    logic signed [OW-1:0] yout_q;
    logic [N:0]           acc_pipe_q;
    logic                 rdy_q;

    assign accept_s   = (phase_q == '0);
    assign bus.in_rdy = accept_s;

    // Phase counter wraps at R-1 so non-power-of-two R also works.
    always_comb begin
        phase_d = phase_q;
        if (phase_q == PH_LAST) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + PW'(1);
        end
    end

    // Phase register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Comb chain: a missing sample on an accept cycle enters as zero.
    always_comb begin
        c_s[0] = '0;
        if (accept_s && bus.in_vld) begin
            c_s[0] = W'(bus.Xin);
        end else begin
            c_s[0] = '0;
        end
        for (int k = 1; k <= N; k++) begin
            c_s[k] = c_s[k-1] - dly_q[k-1][M-1];
        end
        if (accept_s) begin
            u_s = c_s[N];
        end else begin
            u_s = '0;
        end
    end

    // Comb delay lines advance only on accept cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                for (int j = 0; j < M; j++) begin
                    dly_q[k][j] <= '0;
                end
            end
        end else if (accept_s) begin
            for (int k = 0; k < N; k++) begin
                dly_q[k][0] <= c_s[k];
                for (int j = 1; j < M; j++) begin
                    dly_q[k][j] <= dly_q[k][j-1];
                end
            end
        end
    end

    // Zero-stuffed sample register feeding the integrators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            u_reg_q <= '0;
        end else begin
            u_reg_q <= u_s;
        end
    end

    assign i_s[0] = u_reg_q;

    for (genvar k = 0; k < N; k++) begin : g_int
        if (k < N - 1) begin : g_mid
            cic_int_stage #(.W(W), .OUT_W(W)) u_stage (
                .clk   (clk),
                .rst   (rst),
                .en_i  (1'b1),
                .din_i (i_s[k]),
                .acc_o (i_s[k+1])
            );
        end else begin : g_last
            cic_int_stage #(.W(W), .OUT_W(OW)) u_stage (
                .clk   (clk),
                .rst   (rst),
                .en_i  (1'b1),
                .din_i (i_s[k]),
                .acc_o (yacc_s)
            );
        end
    end

    // Output register and accept-tracking pipe that raises the sticky rdy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            yout_q     <= '0;
            acc_pipe_q <= '0;
            rdy_q      <= 1'b0;
        end else begin
            yout_q     <= yacc_s;
            acc_pipe_q <= {acc_pipe_q[N-1:0], accept_s};
            rdy_q      <= rdy_q | acc_pipe_q[N];
        end
    end

    assign bus.Yout = yout_q;
    assign bus.rdy  = rdy_q;

`ifdef CIC_UNDERRUN_EN
    logic first_seen_q;
    logic underrun_q;

    // The very first accept after reset cannot underrun: the source may still be starting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_seen_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else if (accept_s) begin
            first_seen_q <= 1'b1;
            if (first_seen_q && !bus.in_vld) begin
                underrun_q <= 1'b1;
            end
        end
    end

    assign bus.underrun = underrun_q;
`endif

endmodule

// File: tb/tb_cic_interp.sv
// Scoreboard bench for cic_interp: boxcar-convolution reference model, default and swept configurations.
module tb_cic_interp;
    import cic_pkg::*;

    localparam int IW  = 10;
    localparam int OW  = 17;
    localparam int R   = 8;
    localparam int N   = 3;
    localparam int M   = 1;
    localparam int R2  = 4;
    localparam int N2  = 2;
    localparam int M2  = 2;
    localparam int OW2 = IW + N2 * CLOG2(R2 * M2) - CLOG2(R2);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cic_interp_if #(.IW(IW), .OW(OW))  bus1 ();
    cic_interp_if #(.IW(IW), .OW(OW2)) bus2 ();

    cic_interp #(.IW(IW), .OW(OW), .R(R), .N(N), .M(M)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    cic_interp #(.IW(IW), .OW(OW2), .R(R2), .N(N2), .M(M2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int h1[$];
    int h2[$];
    int xu1[$];
    int xu2[$];
    int exp1_q[$];
    int exp2_q[$];
    int ph1, ph2;
    logic und1;
    int checks = 0;
    int passed = 0;
    int fails  = 0;
    logic signed [31:0] y;
    int ysum;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int wrapw(input int v, input int w);
        int s;
        s = 32 - w;
        return (v <<< s) >>> s;
    endfunction

    // Impulse response = N-fold convolution of a length-len boxcar.
    function automatic void mk_h(input int len, input int n, output int h[$]);
        int q[$];
        int nq[$];
        int acc;
        q = {1};
        for (int s = 0; s < n; s++) begin
            nq = {};
            for (int i = 0; i < q.size() + len - 1; i++) begin
                acc = 0;
                for (int k = 0; k < len; k++) begin
                    if (i - k >= 0 && i - k < q.size()) acc += q[i-k];
                end
                nq.push_back(acc);
            end
            q = nq;
        end
        h = q;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_Yout1", bus1.Yout, 0);
        chk("rst_rdy1", bus1.rdy, 0);
        chk("rst_in_rdy1", bus1.in_rdy, 1);
        chk("rst_Yout2", bus2.Yout, 0);
`ifdef CIC_UNDERRUN_EN
        chk("rst_underrun1", bus1.underrun, 0);
`endif
        rst = 1'b0;
        ph1 = 0;
        ph2 = 0;
        und1 = 1'b0;
        xu1.delete();
        xu2.delete();
        exp1_q.delete();
        exp2_q.delete();
        repeat (N + 1)  exp1_q.push_back(0);
        repeat (N2 + 1) exp2_q.push_back(0);
    endtask

    task automatic cyc1(input logic vld, input int x, output logic signed [31:0] yobs);
        logic acc;
        int e;
        int n;
        acc = (ph1 == 0);
        bus1.in_vld = vld;
        bus1.Xin = IW'(x);
        chk("in_rdy1", bus1.in_rdy, acc);
        xu1.push_back((acc && vld) ? x : 0);
        n = xu1.size() - 1;
        e = 0;
        for (int j = 0; j < h1.size() && j <= n; j++) e += h1[j] * xu1[n-j];
        exp1_q.push_back(wrapw(e, OW));
        if (acc && !vld && n != 0) und1 = 1'b1;
        @(posedge clk);
        #1;
        ph1 = (ph1 + 1) % R;
        yobs = bus1.Yout;
        chk("Yout1", yobs, exp1_q.pop_front());
        chk("rdy1", bus1.rdy, (n + 1 >= N + 2));
`ifdef CIC_UNDERRUN_EN
        chk("underrun1", bus1.underrun, und1);
`endif
    endtask

    task automatic cyc2(input logic vld, input int x, output logic signed [31:0] yobs);
        logic acc;
        int e;
        int n;
        acc = (ph2 == 0);
        bus2.in_vld = vld;
        bus2.Xin = IW'(x);
        chk("in_rdy2", bus2.in_rdy, acc);
        xu2.push_back((acc && vld) ? x : 0);
        n = xu2.size() - 1;
        e = 0;
        for (int j = 0; j < h2.size() && j <= n; j++) e += h2[j] * xu2[n-j];
        exp2_q.push_back(wrapw(e, OW2));
        @(posedge clk);
        #1;
        ph2 = (ph2 + 1) % R2;
        yobs = bus2.Yout;
        chk("Yout2", yobs, exp2_q.pop_front());
        chk("rdy2", bus2.rdy, (n + 1 >= N2 + 2));
    endtask

    initial begin
        bus1.Xin = '0;
        bus1.in_vld = 1'b0;
        bus2.Xin = '0;
        bus2.in_vld = 1'b0;
        mk_h(R * M, N, h1);
        mk_h(R2 * M2, N2, h2);

        // Zero input with valid held high.
        do_reset();
        for (int i = 0; i < 24; i++) cyc1(1'b1, 0, y);

        // Impulse of 100 on the first accept.
        do_reset();
        cyc1(1'b1, 100, y);
        ysum = y;
        for (int i = 0; i < 39; i++) begin
            cyc1(1'b1, 0, y);
            ysum += y;
        end
        chk("imp_sum1", ysum, 51200);

        // Full-scale steps in both directions.
        for (int i = 0; i < 48; i++) cyc1(1'b1, 511, y);
        chk("step_pos", y, 32704);
        for (int i = 0; i < 48; i++) cyc1(1'b1, -512, y);
        chk("step_neg", y, -32768);

        // in_vld toggling off-phase, plus one withheld sample at an accept.
        for (int i = 0; i < 40; i++) begin
            logic v;
            v = (ph1 == 0) ? (i != 16) : ((i % 2) != 0);
            cyc1(v, 37, y);
        end
`ifdef CIC_UNDERRUN_EN
        chk("underrun_set", bus1.underrun, 1);
`endif

        // Asynchronous reset in the middle of an impulse response.
        do_reset();
        cyc1(1'b1, 100, y);
        for (int i = 0; i < 13; i++) cyc1(1'b1, 0, y);
        #2 rst = 1'b1;
        #1;
        chk("async_Yout1", bus1.Yout, 0);
        chk("async_rdy1", bus1.rdy, 0);
`ifdef CIC_UNDERRUN_EN
        chk("async_underrun1", bus1.underrun, 0);
`endif
        do_reset();
        cyc1(1'b1, 100, y);
        ysum = y;
        for (int i = 0; i < 39; i++) begin
            cyc1(1'b1, 0, y);
            ysum += y;
        end
        chk("imp_sum1_restart", ysum, 51200);

        // Swept configuration R=4, N=2, M=2.
        do_reset();
        cyc2(1'b1, 100, y);
        ysum = y;
        for (int i = 0; i < 31; i++) begin
            cyc2(1'b1, 0, y);
            ysum += y;
        end
        chk("imp_sum2", ysum, 6400);
        for (int i = 0; i < 40; i++) cyc2(1'b1, 511, y);
        chk("step2_pos", y, 8176);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cic_interp.md
Name: cic_interp

Overview:
- Multi-stage CIC interpolator; the transmit-side counterpart of the Mul_CIC decimator.
- Order of operations: comb chain at the low input rate, zero-stuff by R, then integrator chain at the clk rate.
- Input requested once every R clocks through a valid/ready handshake; output updated every clock.
- Sits between a low-rate sample source and a high-rate DAC/modulator path on the same clk.

Parameters:
- IW, 10: input sample width, signed two's complement.
- OW, 17: output width; must be >= IW + N*CLOG2(R*M) - CLOG2(R).
- R, 8: interpolation factor, >= 2.
- N, 3: number of comb stages and number of integrator stages.
- M, 1: comb differential delay, 1 or 2.

Ports:
- clk  in  1  system clock; one output sample per cycle.
- rst  in  1  asynchronous, active-high reset.
- Xin  in  IW  input sample, signed.
- in_vld  in  1  Xin valid.
- in_rdy  out  1  block accepts Xin this cycle (phase==0).
- Yout  out  OW  interpolated output, signed.
- rdy  out  1  Yout valid; sticky once set.
- underrun  out  1  present only with CIC_UNDERRUN_EN.

Behaviour:
- Reset: clk and rst are the only clock and reset; rst is asynchronous, active-high.
  - While rst is high, phase=0, all comb delays, u_reg and integrators are 0.
  - Outputs during reset: Yout=0, rdy=0, underrun=0.
  - Asserting rst mid-operation clears everything immediately; the first cycle after release is phase 0.
- Phase counter: counts 0..R-1 and wraps to 0. in_rdy = (phase==0), combinational from the register.
- Accept cycle (phase==0):
  - c0 = sign-extended Xin if in_vld=1; c0 = 0 (underrun) if in_vld=0.
  - Comb stage k is combinational from its delay line: c_k = c_(k-1) - D_k, where D_k is c_(k-1) delayed by M accept cycles.
  - The delay lines shift only on accept cycles.
  - u = c_N.
- Non-accept cycles: u = 0 (zero-stuff). in_vld is ignored and no state in the comb chain changes.
- Integrators (pipelined):
  - u_reg <= u.
  - I1 <= I1 + u_reg; Ik <= Ik + I(k-1), all using register values.
- Widths and output:
  - Internal width W = IW + N*CLOG2(R*M). All adds wrap modulo 2^W; no saturation.
  - Yout = I_N[OW-1:0]. This is exact because DC gain = (R*M)^N/R; 64 for the defaults.
- Latency:
  - A sample accepted at edge t first affects Yout after edge t+N+1 (edge t+4 for defaults).
  - rdy goes to 1 on that same edge for the first accepted sample after reset, then stays 1 until reset.
- Handshake boundaries:
  - in_vld high on a non-accept cycle: no effect; the source holds the sample.
  - in_vld and in_rdy both high: sample consumed.
  - Source withholding data at phase 0 (in_vld=0): zero inserted and the output rate is unaffected.
- Defaults: impulse response is (1+z^-1+...+z^-7)^3, 22 taps, symmetric, summing to 512.

Optional Feature:
- Macro: CIC_UNDERRUN_EN.
- Defined:
  - Port underrun exists; it is a sticky flag.
  - It is set on the edge ending any accept cycle with in_vld=0, excluding the first accept cycle after reset.
  - It is cleared only by rst.
- Undefined: port absent and zero insertion is silent. Datapath is identical in both builds.

Decomposition:
- Package cic_pkg:
  - CLOG2 constant function.
  - Default localparams CIC_IW=10, CIC_OW=17, CIC_R=8, CIC_N=3, CIC_M=1.
  - Derived localparam W.
  - Shared with the decimator.
- Sub-module cic_int_stage: one width-parameterised wrap-around accumulator with enable and async reset.
  - Instantiated N times in a generate loop.
  - Combs stay inline: they are small and gated by the accept strobe.

Test Plan:
1. Reset, then hold in_vld=1 with Xin=0 -> Yout=0 for all cycles; rdy=1 from the 4th edge after the first accept; in_rdy high exactly every 8th cycle, starting in the first cycle after release.
2. Impulse: Xin=100 on the first accept, 0 thereafter -> Yout = 100,300,600,1000,1500,2100,2800,3600,... following the 22-tap response ×100; returns to 0; sum of outputs = 51200.
3. Step: Xin=511 held -> Yout settles at 32704; Xin=-512 held -> Yout settles at -32768; no wrap glitches in either case.
4. Handshake: in_vld toggled on non-accept cycles -> output identical to the steady-input case. in_vld=0 at one accept -> treated as a zero sample; underrun=1 from that edge onward (CIC_UNDERRUN_EN build).
5. Reset mid-impulse (rst pulsed at output cycle 10, asynchronously between edges) -> Yout, rdy and underrun go 0 immediately; restart reproduces scenario 2 exactly.
6. Parameter sweep R=4, N=2, M=2, OW=IW+2*3-2 -> DC gain 16; impulse response matches a reference model bit-exactly.
